// File: rtl/axi_lite_slave_regs_if.sv
// AXI-Lite bus bundle shared by the register responder and its masters.
// Channel widths follow the address/data parameters.
interface AXI_LITE #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] awaddr;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;

  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wvalid;
  logic                  wready;

  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;

  logic [ADDR_WIDTH-1:0] araddr;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;

  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport slave (
    input  awaddr, awprot, awvalid,
    output awready,
    input  wdata, wstrb, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready,
    input  araddr, arprot, arvalid,
    output arready,
    output rdata, rresp, rvalid,
    input  rready
  );

  modport master (
    output awaddr, awprot, awvalid,
    input  awready,
    output wdata, wstrb, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready,
    output araddr, arprot, arvalid,
    input  arready,
    input  rdata, rresp, rvalid,
    output rready
  );
endinterface

// File: rtl/axi_lite_slave_regs.sv
// AXI-Lite register bank responder: one outstanding write and one read,
// byte-strobed writes, SLVERR on out-of-range indices.
module axi_lite_slave_regs #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int NUM_REGS   = 4
) (
  input  logic                           clk_i,
  input  logic                           rstn_i,
  AXI_LITE.slave                         axil,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
  output logic [NUM_REGS-1:0]            wr_pulse_o
);

  localparam int IW = ADDR_WIDTH - 2;
  localparam logic [IW:0] NREG = (IW+1)'(NUM_REGS);
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic                  aw_held_q, aw_held_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic                  w_held_q, w_held_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [NUM_REGS-1:0]   wr_pulse_q, wr_pulse_d;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

  logic                  aw_hs, w_hs, ar_hs, commit;
  logic [ADDR_WIDTH-1:0] wr_addr, rd_addr;
  logic [DATA_WIDTH-1:0] wr_data, rd_val;
  logic [STRB_WIDTH-1:0] wr_strb;
  logic [IW-1:0]         wr_idx, rd_idx;
  logic                  wr_ok, rd_ok;

  assign axil.awready = !aw_held_q && !bvalid_q;
  assign axil.wready  = !w_held_q && !bvalid_q;
  assign axil.arready = !rvalid_q;
  assign axil.bvalid  = bvalid_q;
  assign axil.bresp   = bresp_q;
  assign axil.rvalid  = rvalid_q;
  assign axil.rdata   = rdata_q;
  assign axil.rresp   = rresp_q;
  assign wr_pulse_o   = wr_pulse_q;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_o[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
  end

  assign aw_hs = axil.awvalid && !aw_held_q && !bvalid_q;
  assign w_hs  = axil.wvalid && !w_held_q && !bvalid_q;
  assign ar_hs = axil.arvalid && !rvalid_q;

  // A held beat wins over the live bus; the live one is only used on its handshake.
  assign wr_addr = aw_held_q ? awaddr_q : axil.awaddr;
  assign wr_data = w_held_q ? wdata_q : axil.wdata;
  assign wr_strb = w_held_q ? wstrb_q : axil.wstrb;
  assign commit  = (aw_held_q || aw_hs) && (w_held_q || w_hs);

  assign wr_idx = wr_addr[ADDR_WIDTH-1:2];
  assign wr_ok  = {1'b0, wr_idx} < NREG;
  assign rd_addr = axil.araddr;
  assign rd_idx  = rd_addr[ADDR_WIDTH-1:2];
  assign rd_ok   = {1'b0, rd_idx} < NREG;

  logic unused_ok;
  assign unused_ok = ^{axil.awprot, axil.arprot,
                       wr_addr[1:0], rd_addr[1:0]};

  always_comb begin
    aw_held_d = aw_held_q;
    awaddr_d  = awaddr_q;
    w_held_d  = w_held_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    if (aw_hs) begin
      aw_held_d = 1'b1;
      awaddr_d  = axil.awaddr;
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      wdata_d  = axil.wdata;
      wstrb_d  = axil.wstrb;
    end
    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = wr_ok ? OKAY : SLVERR;
    end else if (bvalid_q && axil.bready) begin
      bvalid_d = 1'b0;
    end
  end

  always_comb begin
    wr_pulse_d = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
      if (commit && wr_ok && wr_idx == IW'(i)) begin
        for (int k = 0; k < STRB_WIDTH; k++) begin
          if (wr_strb[k]) regs_d[i][8*k +: 8] = wr_data[8*k +: 8];
        end
        wr_pulse_d[i] = |wr_strb;
      end
    end
  end

  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_idx == IW'(i)) rd_val = regs_q[i];
    end
  end

  // Reads sample regs_q, so a same-edge write is not yet visible.
  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_ok ? rd_val : '0;
      rresp_d  = rd_ok ? OKAY : SLVERR;
    end else if (rvalid_q && axil.rready) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      aw_held_q  <= 1'b0;
      awaddr_q   <= '0;
      w_held_q   <= 1'b0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= OKAY;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= OKAY;
      wr_pulse_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      aw_held_q  <= aw_held_d;
      awaddr_q   <= awaddr_d;
      w_held_q   <= w_held_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      wr_pulse_q <= wr_pulse_d;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
    end
  end

endmodule

// File: tb/tb_axi_lite_slave_regs.sv
// Scoreboard bench for the AXI-Lite register responder (3 registers,
// so index 3 is out of range).
module tb_axi_lite_slave_regs;

  localparam int NR = 3;

  logic          clk;
  logic          rstn;
  logic [95:0]   regs;
  logic [NR-1:0] pulse;

  AXI_LITE #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) bus ();

  axi_lite_slave_regs #(
    .ADDR_WIDTH(4), .DATA_WIDTH(32), .NUM_REGS(NR)
  ) dut (
    .clk_i(clk), .rstn_i(rstn), .axil(bus),
    .regs_o(regs), .wr_pulse_o(pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [31:0] d; logic [1:0] r; } rexp_t;

  logic [1:0]    bq [$];
  rexp_t         rq [$];
  logic [NR-1:0] pq [$];
  logic [31:0]   mreg [NR];
  int n_cmp = 0;
  int n_bad = 0;
  bit stop_rand = 0;

  function automatic void chk(string nm, logic [95:0] act, logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  function automatic logic [95:0] mflat();
    return {mreg[2], mreg[1], mreg[0]};
  endfunction

  // Monitor: pops expectations whenever the DUT completes a response.
  always @(negedge clk) begin
    if (rstn) begin
      if (bus.bvalid && bus.bready) begin
        if (bq.size() == 0) chk("b_unexpected", 1, 0);
        else chk("bresp", bus.bresp, bq.pop_front());
      end
      if (bus.rvalid && bus.rready) begin
        if (rq.size() == 0) chk("r_unexpected", 1, 0);
        else begin
          rexp_t e;
          e = rq.pop_front();
          chk("rdata", bus.rdata, e.d);
          chk("rresp", bus.rresp, e.r);
        end
      end
      if (pulse != '0) begin
        if (pq.size() == 0) chk("pulse_unexpected", pulse, 0);
        else chk("wr_pulse", pulse, pq.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_aw(input logic [3:0] a, input int dly);
    bit ok = 0;
    repeat (dly) tick();
    bus.awaddr = a; bus.awvalid = 1'b1;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk); ok = bus.awready; tick();
      if (ok) break;
    end
    bus.awvalid = 1'b0;
    if (!ok) chk("aw_timeout", 1, 0);
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s, input int dly);
    bit ok = 0;
    repeat (dly) tick();
    bus.wdata = d; bus.wstrb = s; bus.wvalid = 1'b1;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk); ok = bus.wready; tick();
      if (ok) break;
    end
    bus.wvalid = 1'b0;
    if (!ok) chk("w_timeout", 1, 0);
  endtask

  task automatic send_ar(input logic [3:0] a);
    bit ok = 0;
    bus.araddr = a; bus.arvalid = 1'b1;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk); ok = bus.arready; tick();
      if (ok) break;
    end
    bus.arvalid = 1'b0;
    if (!ok) chk("ar_timeout", 1, 0);
  endtask

  task automatic do_write(input logic [3:0] a, input logic [31:0] d,
                          input logic [3:0] s, input int awd, input int wd);
    int idx = int'(a[3:2]);
    logic [NR-1:0] p = '0;
    bq.push_back(idx < NR ? 2'b00 : 2'b10);
    if (idx < NR) begin
      for (int k = 0; k < 4; k++) if (s[k]) mreg[idx][8*k +: 8] = d[8*k +: 8];
      if (s != 4'h0) begin
        p[idx] = 1'b1;
        pq.push_back(p);
      end
    end
    fork
      send_aw(a, awd);
      send_w(d, s, wd);
    join
    chk("b_latency", bus.bvalid, 1);
    chk("regs_o", regs, mflat());
  endtask

  task automatic do_read(input logic [3:0] a);
    int idx = int'(a[3:2]);
    rexp_t e;
    e.d = (idx < NR) ? mreg[idx] : 32'h0;
    e.r = (idx < NR) ? 2'b00 : 2'b10;
    rq.push_back(e);
    send_ar(a);
    chk("r_latency", bus.rvalid, 1);
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int n = 0; n < 200; n++) begin
      if (bq.size() == 0 && rq.size() == 0 && pq.size() == 0) begin
        ok = 1; break;
      end
      tick();
    end
    if (!ok) chk("idle_timeout", 1, 0);
  endtask

  task automatic chk_idle_outputs(string tag);
    chk({tag, "_bvalid"}, bus.bvalid, 0);
    chk({tag, "_rvalid"}, bus.rvalid, 0);
    chk({tag, "_regs"}, regs, 0);
    chk({tag, "_pulse"}, pulse, 0);
    chk({tag, "_awready"}, bus.awready, 1);
    chk({tag, "_wready"}, bus.wready, 1);
    chk({tag, "_arready"}, bus.arready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rstn = 1'b0;
    bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
    bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0;
    bus.bready = 1'b1; bus.rready = 1'b1;
    for (int i = 0; i < NR; i++) mreg[i] = '0;
    #22;
    chk_idle_outputs("rst");
    @(negedge clk); rstn = 1'b1;
    tick();
    chk_idle_outputs("post_rst");

    do_write(4'h4, 32'hDEADBEEF, 4'hF, 0, 0);
    wait_idle();
    do_read(4'h4);
    wait_idle();

    fork
      do_write(4'h8, 32'h12345678, 4'hF, 3, 0);
      begin
        repeat (2) tick();
        chk("wready_held", bus.wready, 0);
        chk("awready_open", bus.awready, 1);
      end
    join
    wait_idle();
    do_write(4'h8, 32'hAABBCCDD, 4'h5, 0, 0);
    chk("reg2_strobe", regs[95:64], 32'h12BB56DD);
    wait_idle();
    do_read(4'hA);
    wait_idle();

    bus.bready = 1'b0;
    do_write(4'h0, 32'h11111111, 4'hF, 0, 0);
    fork
      do_write(4'h0, 32'h22222222, 4'h3, 0, 0);
      begin
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          chk("bvalid_hold", bus.bvalid, 1);
          chk("bresp_hold", bus.bresp, 2'b00);
          chk("awready_block", bus.awready, 0);
          chk("wready_block", bus.wready, 0);
          tick();
        end
        chk("reg0_first", regs[31:0], 32'h11111111);
        bus.bready = 1'b1;
      end
    join
    wait_idle();
    chk("reg0_second", regs[31:0], 32'h11112222);

    do_write(4'hC, 32'h55555555, 4'hF, 0, 0);
    wait_idle();
    do_read(4'hC);
    wait_idle();
    do_read(4'h7);
    wait_idle();

    bus.rready = 1'b0;
    do_read(4'h4);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("rvalid_hold", bus.rvalid, 1);
      chk("rdata_hold", bus.rdata, 32'hDEADBEEF);
      chk("arready_block", bus.arready, 0);
      tick();
    end
    bus.rready = 1'b1;
    wait_idle();

    begin
      rexp_t e;
      e.d = mreg[0]; e.r = 2'b00;
      rq.push_back(e);
    end
    fork
      do_write(4'h0, 32'hCAFEF00D, 4'hF, 0, 0);
      send_ar(4'h0);
    join
    wait_idle();
    do_read(4'h0);
    wait_idle();

    bus.rready = 1'b0;
    do_read(4'h4);
    send_aw(4'h8, 0);
    #3 rstn = 1'b0;
    #1;
    bq.delete(); rq.delete(); pq.delete();
    for (int i = 0; i < NR; i++) mreg[i] = '0;
    chk_idle_outputs("mid_rst");
    @(negedge clk); rstn = 1'b1;
    bus.rready = 1'b1;
    tick();
    chk_idle_outputs("mid_post");
    do_write(4'h4, 32'h0BADF00D, 4'hF, 2, 0);
    wait_idle();

    fork
      while (!stop_rand) begin
        bus.bready = 1'($urandom_range(0, 1));
        bus.rready = 1'($urandom_range(0, 1));
        tick();
      end
      begin
        for (int t = 0; t < 40; t++) begin
          logic [3:0] a;
          a = 4'($urandom_range(0, 15));
          if ($urandom_range(0, 1) == 1)
            do_write(a, $urandom, 4'($urandom_range(0, 15)),
                     $urandom_range(0, 3), $urandom_range(0, 3));
          else
            do_read(a);
        end
        wait_idle();
        stop_rand = 1;
      end
    join
    bus.bready = 1'b1; bus.rready = 1'b1;
    tick();
    chk("final_regs", regs, mflat());
    chk("bq_empty", bq.size(), 0);
    chk("rq_empty", rq.size(), 0);
    chk("pq_empty", pq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
